// File: rtl/wb_multiport.sv
// Multi-lane write-back stage: holds one entry of up to LANES results, drives the
// register-file write ports, commits HI/LO once per entry and counts retired lanes.
module wb_multiport #(
   parameter int LANES = 2,
   parameter int DW    = 32,
   parameter int CNTW  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_wb,
   input  logic                  stall_next,
   input  logic                  flush,
   input  logic [LANES-1:0]      in_valid,
   input  logic [LANES*32-1:0]   in_pc,
   input  logic [LANES-1:0]      in_we,
   input  logic [LANES*5-1:0]    in_waddr,
   input  logic [LANES*DW-1:0]   in_wdata,
   input  logic [LANES*2-1:0]    in_hilo_op,
   input  logic [LANES*2*DW-1:0] in_hilo_data,
   output logic [LANES-1:0]      rf_we,
   output logic [LANES*5-1:0]    rf_waddr,
   output logic [LANES*DW-1:0]   rf_wdata,
   output logic [DW-1:0]         hi_q,
   output logic [DW-1:0]         lo_q,
   output logic [DW-1:0]         hi_fwd,
   output logic [DW-1:0]         lo_fwd,
   output logic [CNTW-1:0]       retired,
   output logic [LANES*32-1:0]   debug_wb_pc,
   output logic [LANES*4-1:0]    debug_wb_rf_wen
);

   function automatic logic [CNTW-1:0] popcount(input logic [LANES-1:0] v);
      logic [CNTW-1:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) begin
         n = n + CNTW'(v[i]);
      end
      return n;
   endfunction

   logic [LANES-1:0]      valid_r;
   logic [LANES*32-1:0]   pc_r;
   logic [LANES-1:0]      we_r;
   logic [LANES*5-1:0]    waddr_r;
   logic [LANES*DW-1:0]   wdata_r;
   logic [LANES*2-1:0]    hilo_op_r;
   logic [LANES*2*DW-1:0] hilo_data_r;
   logic                  fresh_r;
   logic [DW-1:0]         hi_r;
   logic [DW-1:0]         lo_r;
   logic [CNTW-1:0]       retired_r;

   logic                  load_bubble_s;
   logic                  capture_s;
   logic                  kill_s;
   logic [DW-1:0]         hi_upd_s;
   logic [DW-1:0]         lo_upd_s;

   assign load_bubble_s = flush | (stall_wb & ~stall_next);
   assign capture_s     = ~stall_wb & ~flush;

   // Entry register: reset > flush/bubble > capture > hold; fresh marks the first presented cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r     <= '0;
         pc_r        <= '0;
         we_r        <= '0;
         waddr_r     <= '0;
         wdata_r     <= '0;
         hilo_op_r   <= '0;
         hilo_data_r <= '0;
         fresh_r     <= 1'b0;
      end else if (load_bubble_s) begin
         valid_r     <= '0;
         pc_r        <= '0;
         we_r        <= '0;
         waddr_r     <= '0;
         wdata_r     <= '0;
         hilo_op_r   <= '0;
         hilo_data_r <= '0;
         fresh_r     <= 1'b0;
      end else if (capture_s) begin
         valid_r     <= in_valid;
         pc_r        <= in_pc;
         we_r        <= in_we;
         waddr_r     <= in_waddr;
         wdata_r     <= in_wdata;
         hilo_op_r   <= in_hilo_op;
         hilo_data_r <= in_hilo_data;
         fresh_r     <= |in_valid;
      end else begin
         fresh_r     <= 1'b0;
      end
   end

   // Pending HI/LO value: youngest selecting lane wins, only during the fresh cycle.
   always_comb begin
      hi_upd_s = hi_r;
      lo_upd_s = lo_r;
      if (fresh_r) begin
         for (int i = 0; i < LANES; i++) begin
            hi_upd_s = (valid_r[i] && hilo_op_r[2*i])   ? hilo_data_r[2*DW*i+DW +: DW] : hi_upd_s;
            lo_upd_s = (valid_r[i] && hilo_op_r[2*i+1]) ? hilo_data_r[2*DW*i +: DW]    : lo_upd_s;
         end
      end else begin
         hi_upd_s = hi_r;
         lo_upd_s = lo_r;
      end
   end

   // Architectural HI/LO and retired counter advance once per fresh entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r      <= '0;
         lo_r      <= '0;
         retired_r <= '0;
      end else begin
         hi_r      <= hi_upd_s;
         lo_r      <= lo_upd_s;
         retired_r <= retired_r + (fresh_r ? popcount(valid_r) : '0);
      end
   end

   // Write strobes: a lane is suppressed when a younger lane writes the same register.
   always_comb begin
      rf_we           = '0;
      debug_wb_rf_wen = '0;
      kill_s          = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         kill_s = 1'b0;
         for (int j = i + 1; j < LANES; j++) begin
            kill_s = kill_s | (valid_r[j] & we_r[j] & (waddr_r[5*j +: 5] == waddr_r[5*i +: 5]));
         end
         rf_we[i] = valid_r[i] & we_r[i] & (waddr_r[5*i +: 5] != 5'd0) & ~kill_s;
         debug_wb_rf_wen[4*i +: 4] = {4{rf_we[i]}};
      end
   end

   assign rf_waddr    = waddr_r;
   assign rf_wdata    = wdata_r;
   assign debug_wb_pc = pc_r;
   assign hi_q        = hi_r;
   assign lo_q        = lo_r;
   assign hi_fwd      = hi_upd_s;
   assign lo_fwd      = lo_upd_s;
   assign retired     = retired_r;

endmodule

// File: tb/tb_wb_multiport.sv
// Self-checking bench for wb_multiport: directed scenarios then random traffic,
// compared each cycle against a lane-array reference model.
module tb_wb_multiport;
   localparam int L  = 2;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            stall_wb = 1'b0;
   logic            stall_next = 1'b0;
   logic            flush = 1'b0;
   logic [L-1:0]    in_valid = '0;
   logic [L*32-1:0] in_pc = '0;
   logic [L-1:0]    in_we = '0;
   logic [L*5-1:0]  in_waddr = '0;
   logic [L*DW-1:0] in_wdata = '0;
   logic [L*2-1:0]  in_hilo_op = '0;
   logic [L*2*DW-1:0] in_hilo_data = '0;

   logic [L-1:0]    rf_we;
   logic [L*5-1:0]  rf_waddr;
   logic [L*DW-1:0] rf_wdata;
   logic [DW-1:0]   hi_q, lo_q, hi_fwd, lo_fwd;
   logic [31:0]     retired;
   logic [L*32-1:0] debug_wb_pc;
   logic [L*4-1:0]  debug_wb_rf_wen;

   logic [L-1:0]    w_rf_we;
   logic [L*5-1:0]  w_rf_waddr;
   logic [L*DW-1:0] w_rf_wdata;
   logic [DW-1:0]   w_hi_q, w_lo_q, w_hi_fwd, w_lo_fwd;
   logic [3:0]      w_retired;
   logic [L*32-1:0] w_debug_wb_pc;
   logic [L*4-1:0]  w_debug_wb_rf_wen;

   wb_multiport #(.LANES(L), .DW(DW), .CNTW(32)) u_dut (
      .clk(clk), .rst(rst), .stall_wb(stall_wb), .stall_next(stall_next), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_we(in_we), .in_waddr(in_waddr),
      .in_wdata(in_wdata), .in_hilo_op(in_hilo_op), .in_hilo_data(in_hilo_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .hi_q(hi_q), .lo_q(lo_q), .hi_fwd(hi_fwd), .lo_fwd(lo_fwd), .retired(retired),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen));

   wb_multiport #(.LANES(L), .DW(DW), .CNTW(4)) u_wrap (
      .clk(clk), .rst(rst), .stall_wb(stall_wb), .stall_next(stall_next), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_we(in_we), .in_waddr(in_waddr),
      .in_wdata(in_wdata), .in_hilo_op(in_hilo_op), .in_hilo_data(in_hilo_data),
      .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
      .hi_q(w_hi_q), .lo_q(w_lo_q), .hi_fwd(w_hi_fwd), .lo_fwd(w_lo_fwd), .retired(w_retired),
      .debug_wb_pc(w_debug_wb_pc), .debug_wb_rf_wen(w_debug_wb_rf_wen));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: the held entry as per-lane arrays plus architectural state.
   bit          e_v [L];
   bit          e_we[L];
   logic [4:0]  e_a [L];
   logic [31:0] e_d [L];
   logic [31:0] e_pc[L];
   logic [1:0]  e_op[L];
   logic [31:0] e_hi[L];
   logic [31:0] e_lo[L];
   bit          first = 1'b0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   longint unsigned m_ret = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_entry();
      for (int i = 0; i < L; i++) begin
         e_v[i] = 1'b0; e_we[i] = 1'b0; e_op[i] = 2'b00;
         e_a[i] = 5'd0; e_d[i] = 32'd0; e_pc[i] = 32'd0; e_hi[i] = 32'd0; e_lo[i] = 32'd0;
      end
   endtask

   task automatic pending(output logic [31:0] h, output logic [31:0] l);
      h = m_hi;
      l = m_lo;
      if (first) begin
         for (int i = 0; i < L; i++) begin
            if (e_v[i] && e_op[i][0]) h = e_hi[i];
            if (e_v[i] && e_op[i][1]) l = e_lo[i];
         end
      end
   endtask

   task automatic model_edge();
      logic [31:0] h, l;
      if (rst) begin
         clear_entry();
         first = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_ret = 0;
      end else begin
         pending(h, l);
         m_hi = h;
         m_lo = l;
         if (first) begin
            for (int i = 0; i < L; i++) m_ret += e_v[i] ? 1 : 0;
         end
         if (flush || (stall_wb && !stall_next)) begin
            clear_entry();
            first = 1'b0;
         end else if (!stall_wb) begin
            first = 1'b0;
            for (int i = 0; i < L; i++) begin
               e_v[i]  = in_valid[i];
               e_we[i] = in_we[i];
               e_a[i]  = in_waddr[5*i +: 5];
               e_d[i]  = in_wdata[32*i +: 32];
               e_pc[i] = in_pc[32*i +: 32];
               e_op[i] = in_hilo_op[2*i +: 2];
               e_hi[i] = in_hilo_data[64*i+32 +: 32];
               e_lo[i] = in_hilo_data[64*i +: 32];
               if (in_valid[i]) first = 1'b1;
            end
         end else begin
            first = 1'b0;
         end
      end
   endtask

   task automatic check_model();
      logic [L-1:0] exp_we;
      logic [31:0]  h, l;
      for (int i = 0; i < L; i++) begin
         exp_we[i] = e_v[i] && e_we[i] && (e_a[i] != 5'd0);
         for (int j = i + 1; j < L; j++) begin
            if (e_v[j] && e_we[j] && e_a[j] == e_a[i]) exp_we[i] = 1'b0;
         end
      end
      chk("rf_we", rf_we, exp_we);
      chk("dbg_wen", debug_wb_rf_wen, {{4{exp_we[1]}}, {4{exp_we[0]}}});
      for (int i = 0; i < L; i++) begin
         if (e_v[i]) begin
            chk("rf_waddr", rf_waddr[5*i +: 5], e_a[i]);
            chk("rf_wdata", rf_wdata[32*i +: 32], e_d[i]);
            chk("dbg_pc", debug_wb_pc[32*i +: 32], e_pc[i]);
         end
      end
      pending(h, l);
      chk("hi_fwd", hi_fwd, h);
      chk("lo_fwd", lo_fwd, l);
      chk("hi_q", hi_q, m_hi);
      chk("lo_q", lo_q, m_lo);
      chk("retired", retired, m_ret[31:0]);
      chk("retired_w4", w_retired, m_ret[3:0]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic set_lane(input int i, input bit v, input bit we, input logic [4:0] a,
                           input logic [31:0] d, input logic [1:0] op,
                           input logic [31:0] hi, input logic [31:0] lo);
      in_valid[i]            = v;
      in_we[i]               = we;
      in_waddr[5*i +: 5]     = a;
      in_wdata[32*i +: 32]   = d;
      in_pc[32*i +: 32]      = 32'h0040_0000 + 32'(4 * i);
      in_hilo_op[2*i +: 2]   = op;
      in_hilo_data[64*i +: 64] = {hi, lo};
   endtask

   task automatic idle_lanes();
      for (int i = 0; i < L; i++) set_lane(i, 1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 32'd0, 32'd0);
   endtask

   task automatic rand_lanes();
      for (int i = 0; i < L; i++) begin
         set_lane(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  $urandom, 2'($urandom_range(0, 3)), $urandom, $urandom);
         in_pc[32*i +: 32] = $urandom;
      end
   endtask

   initial begin
      clear_entry();
      // Reset with live inputs: nothing may be captured or counted.
      rst = 1'b1;
      rand_lanes();
      in_valid = 2'b11;
      tick();
      tick();
      chk("rst_rf_we", rf_we, 2'b00);
      chk("rst_waddr", rf_waddr, 10'd0);
      chk("rst_wdata", rf_wdata, 64'd0);
      chk("rst_pc", debug_wb_pc, 64'd0);
      chk("rst_wen", debug_wb_rf_wen, 8'd0);
      chk("rst_hi_fwd", hi_fwd, 32'd0);
      chk("rst_retired", retired, 32'd0);

      // Same-address conflict: younger lane wins.
      rst = 1'b0;
      set_lane(0, 1'b1, 1'b1, 5'd3, 32'h11, 2'b00, 32'd0, 32'd0);
      set_lane(1, 1'b1, 1'b1, 5'd3, 32'h22, 2'b00, 32'd0, 32'd0);
      tick();
      chk("conf_we", rf_we, 2'b10);
      chk("conf_data", rf_wdata[63:32], 32'h22);
      idle_lanes();
      tick();
      chk("conf_ret", retired, 32'd2);

      // Write to r0 is suppressed but still retires.
      set_lane(0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 2'b00, 32'd0, 32'd0);
      tick();
      chk("r0_we", rf_we[0], 1'b0);
      idle_lanes();
      tick();
      chk("r0_ret", retired, 32'd3);

      // HI/LO per-half youngest wins; forwarded in the presented cycle.
      set_lane(0, 1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 32'hA, 32'hB);
      set_lane(1, 1'b1, 1'b0, 5'd0, 32'd0, 2'b10, 32'h1234, 32'hC);
      tick();
      chk("hl_hi_fwd", hi_fwd, 32'hA);
      chk("hl_lo_fwd", lo_fwd, 32'hC);
      chk("hl_hi_q_old", hi_q, 32'd0);
      idle_lanes();
      tick();
      chk("hl_hi_q", hi_q, 32'hA);
      chk("hl_lo_q", lo_q, 32'hC);

      // Hold for three cycles: constant outputs, counted once; then bubble.
      set_lane(0, 1'b1, 1'b1, 5'd5, 32'h55, 2'b01, 32'h55, 32'd0);
      set_lane(1, 1'b1, 1'b1, 5'd6, 32'h66, 2'b00, 32'd0, 32'd0);
      tick();
      chk("hold_cap_we", rf_we, 2'b11);
      stall_wb = 1'b1;
      stall_next = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rand_lanes();
         tick();
         chk("hold_we", rf_we, 2'b11);
         chk("hold_data", rf_wdata, {32'h66, 32'h55});
         chk("hold_ret", retired, 32'd7);
         chk("hold_hi", hi_q, 32'h55);
      end
      stall_next = 1'b0;
      tick();
      chk("bubble_we", rf_we, 2'b00);
      chk("bubble_ret", retired, 32'd7);

      // Flush with valid inputs loads a bubble.
      stall_wb = 1'b0;
      flush = 1'b1;
      set_lane(0, 1'b1, 1'b1, 5'd7, 32'h77, 2'b11, 32'h1, 32'h2);
      set_lane(1, 1'b1, 1'b1, 5'd8, 32'h88, 2'b11, 32'h3, 32'h4);
      tick();
      chk("flush_we", rf_we, 2'b00);
      flush = 1'b0;
      idle_lanes();
      tick();
      chk("flush_ret", retired, 32'd7);
      chk("flush_hi", hi_q, 32'h55);

      // Counter wrap on the 4-bit instance: 15 then +2 -> 1.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 9; k++) begin
         set_lane(0, 1'b1, 1'b1, 5'd1, 32'(k), 2'b00, 32'd0, 32'd0);
         set_lane(1, (k != 7), 1'b1, 5'd2, 32'(k), 2'b00, 32'd0, 32'd0);
         tick();
      end
      chk("wrap_15", w_retired, 4'd15);
      idle_lanes();
      tick();
      chk("wrap_1", w_retired, 4'd1);
      chk("wrap_full", retired, 32'd17);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 99) < 3);
         flush      = ($urandom_range(0, 99) < 8);
         stall_wb   = ($urandom_range(0, 99) < 30);
         stall_next = ($urandom_range(0, 99) < 50);
         rand_lanes();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
